// File: rtl/util_debounce.sv
// Per-bit glitch filter: a bit's debounced level follows data_i only after the new
// value has been seen on Neff consecutive edges, with one-cycle rise/fall pulses.
module util_debounce #(
    parameter int WIDTH     = 1,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 reset_n_i,
    input  logic                 enable_i,
    input  logic [CNT_WIDTH-1:0] thresh_i,
    input  logic [WIDTH-1:0]     data_i,
    output logic [WIDTH-1:0]     level_o,
    output logic [WIDTH-1:0]     rise_o,
    output logic [WIDTH-1:0]     fall_o,
    output logic                 busy_o
);

    // Neff-1, with a zero threshold behaving like a threshold of one
    logic [CNT_WIDTH-1:0] w_thr_m1;
    logic [WIDTH-1:0]     w_cnt_nz_next;
    logic                 r_busy;

    assign w_thr_m1 = (thresh_i == '0) ? '0 : thresh_i - 1'b1;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            logic [CNT_WIDTH-1:0] r_cnt;
            logic [CNT_WIDTH-1:0] w_cnt_next;
            logic                 r_level;
            logic                 w_level_next;
            logic                 r_rise;
            logic                 w_rise_next;
            logic                 r_fall;
            logic                 w_fall_next;

            always_comb begin
                w_cnt_next   = '0;
                w_level_next = r_level;
                w_rise_next  = 1'b0;
                w_fall_next  = 1'b0;
                if (enable_i && (data_i[gi] != r_level)) begin
                    // >= lets a lowered threshold complete on the next mismatch
                    if (r_cnt >= w_thr_m1) begin
                        w_level_next = data_i[gi];
                        w_rise_next  = data_i[gi];
                        w_fall_next  = ~data_i[gi];
                    end else begin
                        w_cnt_next = r_cnt + 1'b1;
                    end
                end
            end

            always_ff @(posedge clk_i or negedge reset_n_i) begin
                if (!reset_n_i) begin
                    r_cnt   <= '0;
                    r_level <= 1'b0;
                    r_rise  <= 1'b0;
                    r_fall  <= 1'b0;
                end else begin
                    r_cnt   <= w_cnt_next;
                    r_level <= w_level_next;
                    r_rise  <= w_rise_next;
                    r_fall  <= w_fall_next;
                end
            end

            assign level_o[gi]       = r_level;
            assign rise_o[gi]        = r_rise;
            assign fall_o[gi]        = r_fall;
            assign w_cnt_nz_next[gi] = |w_cnt_next;
        end
    endgenerate

    // Registered from next-state so busy_o tracks the counters in the same cycle
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_busy <= 1'b0;
        end else begin
            r_busy <= |w_cnt_nz_next;
        end
    end

    assign busy_o = r_busy;

endmodule

// File: tb/tb_util_debounce.sv
// Scoreboard bench for util_debounce: a cycle model pushes expected outputs per
// driven cycle, each scenario task pops and compares after the edge.
module tb_util_debounce;

    localparam int W  = 4;
    localparam int CW = 16;

    typedef struct packed {
        logic [W-1:0] level;
        logic [W-1:0] rise;
        logic [W-1:0] fall;
        logic         busy;
    } exp_t;

    logic          clk_i = 1'b0;
    logic          reset_n_i;
    logic          enable_i;
    logic [CW-1:0] thresh_i;
    logic [W-1:0]  data_i;
    logic [W-1:0]  level_o, rise_o, fall_o;
    logic          busy_o;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb_q[$];
    exp_t got, e;

    logic [W-1:0] m_level;
    logic [W-1:0] m_rise, m_fall;
    logic         m_busy;
    int           m_cnt[W];

    util_debounce #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .enable_i  (enable_i),
        .thresh_i  (thresh_i),
        .data_i    (data_i),
        .level_o   (level_o),
        .rise_o    (rise_o),
        .fall_o    (fall_o),
        .busy_o    (busy_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL timeout bench did not finish");
        $fatal(1, "timeout");
    end

    task automatic model_reset();
        m_level = '0; m_rise = '0; m_fall = '0; m_busy = 1'b0;
        for (int b = 0; b < W; b++) m_cnt[b] = 0;
    endtask

    // Drive one cycle of stimulus, push the expected post-edge outputs, wait for the edge
    task automatic cycle(input logic en, input logic [CW-1:0] th, input logic [W-1:0] d);
        int neff1;
        exp_t x;
        @(negedge clk_i);
        enable_i = en; thresh_i = th; data_i = d;
        neff1 = (th == 0) ? 0 : int'(th) - 1;
        m_busy = 1'b0;
        for (int b = 0; b < W; b++) begin
            m_rise[b] = 1'b0;
            m_fall[b] = 1'b0;
            if (!en || d[b] == m_level[b]) begin
                m_cnt[b] = 0;
            end else if (m_cnt[b] >= neff1) begin
                m_level[b] = d[b];
                m_rise[b]  = d[b];
                m_fall[b]  = ~d[b];
                m_cnt[b]   = 0;
            end else begin
                m_cnt[b] = m_cnt[b] + 1;
            end
            if (m_cnt[b] != 0) m_busy = 1'b1;
        end
        x.level = m_level; x.rise = m_rise; x.fall = m_fall; x.busy = m_busy;
        sb_q.push_back(x);
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        reset_n_i = 1'b0; enable_i = 1'b0; thresh_i = '0; data_i = '0;
        model_reset();
        #3;
        got = {level_o, rise_o, fall_o, busy_o};
        n_checks++;
        if (got !== exp_t'(0)) begin
            n_fail++; $display("FAIL reset_state got=%h exp=0", got);
        end
        repeat (3) @(posedge clk_i);
        #2 reset_n_i = 1'b1;
        cycle(1'b1, 16'd4, 4'b0000);
        got = {level_o, rise_o, fall_o, busy_o}; e = sb_q.pop_front(); n_checks++;
        if (got !== e) begin n_fail++; $display("FAIL reset_release got=%h exp=%h", got, e); end
    endtask

    task automatic test_basic_rise();
        int first_rise = 0;
        int busy_cnt   = 0;
        for (int i = 1; i <= 6; i++) begin
            cycle(1'b1, 16'd4, 4'b0001);
            got = {level_o, rise_o, fall_o, busy_o}; e = sb_q.pop_front(); n_checks++;
            if (got !== e) begin n_fail++; $display("FAIL basic_rise cyc=%0d got=%h exp=%h", i, got, e); end
            if (rise_o[0] && first_rise == 0) first_rise = i;
            if (busy_o) busy_cnt++;
        end
        n_checks++;
        if (first_rise != 4) begin n_fail++; $display("FAIL basic_rise_latency got=%0d exp=4", first_rise); end
        n_checks++;
        if (busy_cnt != 3) begin n_fail++; $display("FAIL basic_rise_busy got=%0d exp=3", busy_cnt); end
        for (int i = 1; i <= 4; i++) begin
            cycle(1'b1, 16'd4, 4'b0000);
            got = {level_o, rise_o, fall_o, busy_o}; e = sb_q.pop_front(); n_checks++;
            if (got !== e) begin n_fail++; $display("FAIL basic_fall cyc=%0d got=%h exp=%h", i, got, e); end
        end
        n_checks++;
        if (level_o !== 4'b0000) begin n_fail++; $display("FAIL basic_fall_level got=%b exp=0000", level_o); end
    endtask

    task automatic test_glitch();
        logic [W-1:0] pat[5] = '{4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000};
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 16'd4, pat[i]);
            got = {level_o, rise_o, fall_o, busy_o}; e = sb_q.pop_front(); n_checks++;
            if (got !== e) begin n_fail++; $display("FAIL glitch cyc=%0d got=%h exp=%h", i, got, e); end
            if (i == 3) begin
                n_checks++;
                if (busy_o !== 1'b0 || level_o !== 4'b0000 || rise_o !== 4'b0000) begin
                    n_fail++; $display("FAIL glitch_cleared busy=%b level=%b rise=%b exp 0/0000/0000", busy_o, level_o, rise_o);
                end
            end
        end
    endtask

    task automatic test_thresh01();
        for (int t = 0; t <= 1; t++) begin
            cycle(1'b1, CW'(t), 4'b0001);
            got = {level_o, rise_o, fall_o, busy_o}; e = sb_q.pop_front(); n_checks++;
            if (got !== e) begin n_fail++; $display("FAIL thr%0d_rise got=%h exp=%h", t, got, e); end
            cycle(1'b1, CW'(t), 4'b0000);
            got = {level_o, rise_o, fall_o, busy_o}; e = sb_q.pop_front(); n_checks++;
            if (got !== e) begin n_fail++; $display("FAIL thr%0d_fall got=%h exp=%h", t, got, e); end
            n_checks++;
            if (fall_o !== 4'b0001 || level_o !== 4'b0000) begin
                n_fail++; $display("FAIL thr%0d_fall_pulse fall=%b level=%b exp 0001/0000", t, fall_o, level_o);
            end
            cycle(1'b1, CW'(t), 4'b0000);
            got = {level_o, rise_o, fall_o, busy_o}; e = sb_q.pop_front(); n_checks++;
            if (got !== e) begin n_fail++; $display("FAIL thr%0d_idle got=%h exp=%h", t, got, e); end
        end
    endtask

    task automatic test_multibit();
        logic [W-1:0] pat[7] = '{4'b0111, 4'b0111, 4'b0101, 4'b0101, 4'b0000, 4'b0000, 4'b0000};
        for (int i = 0; i < 7; i++) begin
            cycle(1'b1, 16'd3, pat[i]);
            got = {level_o, rise_o, fall_o, busy_o}; e = sb_q.pop_front(); n_checks++;
            if (got !== e) begin n_fail++; $display("FAIL multibit cyc=%0d got=%h exp=%h", i, got, e); end
            if (i == 2) begin
                n_checks++;
                if (rise_o !== 4'b0101 || level_o !== 4'b0101) begin
                    n_fail++; $display("FAIL multibit_rise rise=%b level=%b exp 0101/0101", rise_o, level_o);
                end
            end
        end
    endtask

    task automatic test_enable();
        int rise_at = 0;
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 16'd8, 4'b0001);
            got = {level_o, rise_o, fall_o, busy_o}; e = sb_q.pop_front(); n_checks++;
            if (got !== e) begin n_fail++; $display("FAIL enable_pre cyc=%0d got=%h exp=%h", i, got, e); end
        end
        for (int i = 0; i < 2; i++) begin
            cycle(1'b0, 16'd8, 4'b0001);
            got = {level_o, rise_o, fall_o, busy_o}; e = sb_q.pop_front(); n_checks++;
            if (got !== e) begin n_fail++; $display("FAIL enable_off cyc=%0d got=%h exp=%h", i, got, e); end
        end
        for (int i = 1; i <= 9; i++) begin
            cycle(1'b1, 16'd8, 4'b0001);
            got = {level_o, rise_o, fall_o, busy_o}; e = sb_q.pop_front(); n_checks++;
            if (got !== e) begin n_fail++; $display("FAIL enable_on cyc=%0d got=%h exp=%h", i, got, e); end
            if (rise_o[0] && rise_at == 0) rise_at = i;
        end
        n_checks++;
        if (rise_at != 8) begin n_fail++; $display("FAIL enable_reenable_latency got=%0d exp=8", rise_at); end
        // Lowered threshold: fall after 5 mismatches at 8, then one edge at 3
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, (i < 5) ? 16'd8 : 16'd3, 4'b0000);
            got = {level_o, rise_o, fall_o, busy_o}; e = sb_q.pop_front(); n_checks++;
            if (got !== e) begin n_fail++; $display("FAIL lower_thr cyc=%0d got=%h exp=%h", i, got, e); end
        end
        n_checks++;
        if (fall_o !== 4'b0001) begin n_fail++; $display("FAIL lower_thr_fall got=%b exp=0001", fall_o); end
    endtask

    task automatic test_reset_mid();
        int rise_at = 0;
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, 16'd10, 4'b0001);
            got = {level_o, rise_o, fall_o, busy_o}; e = sb_q.pop_front(); n_checks++;
            if (got !== e) begin n_fail++; $display("FAIL rst_mid_pre cyc=%0d got=%h exp=%h", i, got, e); end
        end
        #2 reset_n_i = 1'b0;
        model_reset();
        #1;
        got = {level_o, rise_o, fall_o, busy_o}; n_checks++;
        if (got !== exp_t'(0)) begin n_fail++; $display("FAIL rst_mid_async got=%h exp=0", got); end
        repeat (2) @(posedge clk_i);
        #2 reset_n_i = 1'b1;
        for (int i = 1; i <= 11; i++) begin
            cycle(1'b1, 16'd10, 4'b0001);
            got = {level_o, rise_o, fall_o, busy_o}; e = sb_q.pop_front(); n_checks++;
            if (got !== e) begin n_fail++; $display("FAIL rst_mid_post cyc=%0d got=%h exp=%h", i, got, e); end
            if (rise_o[0] && rise_at == 0) rise_at = i;
        end
        n_checks++;
        if (rise_at != 10) begin n_fail++; $display("FAIL rst_mid_latency got=%0d exp=10", rise_at); end
    endtask

    initial begin
        test_reset();
        test_basic_rise();
        test_glitch();
        test_thresh01();
        test_multibit();
        test_enable();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
